// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one single-port memory bus between the instruction-fetch port and
//   the data-access port of the pipeline. This lets the core run against a
//   single external RAM instead of split I/D memories. Each granted request
//   runs as one request/acknowledge transaction on the memory side. Read data
//   and a one-cycle completion strobe go back to the requester that owns the
//   transaction. Requesters use the ack strobes to drive their stall logic.
//
//   Fixed priority: data wins over instruction, because the data access
//   belongs to the older instruction in the pipeline.
//
// Optional feature (macro MEM_ARB_STARVE_GUARD_EN):
//   When defined, a run counter limits how many data grants can be made
//   back-to-back while an instruction fetch is waiting. After MAX_D_RUN such
//   grants, the fetch is served next. When undefined, no counter logic
//   exists and data always wins.
//
// Parameters:
//   AW        address width in bits
//   DW        data width in bits
//   MAX_D_RUN data grants allowed while a fetch waits (starve guard only)
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   i_req/i_addr         fetch request (read only) and byte address
//   i_rdata/i_ack        fetch read data and one-cycle completion strobe
//   d_req/d_we/d_addr    data request, write enable, and byte address
//   d_wdata              data write data
//   d_rdata/d_ack        data read data and one-cycle completion strobe
//   m_req/m_we/m_addr    memory request, write enable, word-aligned address
//   m_wdata              memory write data
//   m_rdata/m_ack        memory read data and completion strobe
//   owner                current bus owner: 00 none, 01 instruction, 10 data
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_D_RUN = 4
) (
    input  logic          clk,
    input  logic          rst,
    // instruction-fetch port
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    // data-access port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    // unified memory bus
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    // status
    output logic [1:0]    owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2,
        ACK    = 2'd3
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_I    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

    state_t        state_q,   state_d;
    logic          m_req_q,   m_req_d;
    logic          m_we_q,    m_we_d;
    logic [AW-1:0] m_addr_q,  m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic [1:0]    owner_q,   owner_d;
    logic          i_ack_q,   i_ack_d;
    logic          d_ack_q,   d_ack_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    // High when an IDLE cycle should hand the bus to the data port.
    logic grant_data;

    // The two low address bits never reach the bus; memory is word-addressed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

`ifdef MEM_ARB_STARVE_GUARD_EN
    // One extra count value keeps the width valid even for MAX_D_RUN = 0.
    localparam int RUN_W = $clog2(MAX_D_RUN + 2);

    logic [RUN_W-1:0] run_q, run_d;
    logic             run_at_limit;

    assign run_at_limit = (run_q == RUN_W'(MAX_D_RUN));

    // Once the fetch has waited through MAX_D_RUN data grants, the next
    // IDLE grant goes to the fetch even if data is still requesting.
    assign grant_data = d_req && !(i_req && run_at_limit);

    // The counter only counts data grants that made a fetch wait. It clears
    // when the fetch wins, or whenever the fetch is not requesting in IDLE.
    always_comb begin
        run_d = run_q;
        if (state_q == IDLE) begin
            if (!i_req) begin
                run_d = '0;
            end else if (grant_data) begin
                run_d = run_q + 1'b1;
            end else begin
                run_d = '0;
            end
        end
    end
`else
    assign grant_data = d_req;

    logic unused_cfg;
    assign unused_cfg = (MAX_D_RUN > 0);
`endif

    // Next-state and next-output logic. All bus outputs come straight from
    // flops, so the grant in IDLE loads the bus registers directly. Those
    // registers are also the latched copy of the request. They stay stable
    // for the whole WAIT state regardless of what the requester does.
    always_comb begin
        state_d   = state_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        owner_d   = owner_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d   = D_WAIT;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = {d_addr[AW-1:2], 2'b00};
                    m_wdata_d = d_wdata;
                    owner_d   = OWN_D;
                end else if (i_req) begin
                    state_d  = I_WAIT;
                    m_req_d  = 1'b1;
                    m_we_d   = 1'b0;
                    m_addr_d = {i_addr[AW-1:2], 2'b00};
                    owner_d  = OWN_I;
                end
            end

            I_WAIT: begin
                if (m_ack) begin
                    state_d   = ACK;
                    m_req_d   = 1'b0;
                    m_we_d    = 1'b0;
                    i_ack_d   = 1'b1;
                    i_rdata_d = m_rdata;
                end
            end

            D_WAIT: begin
                if (m_ack) begin
                    state_d = ACK;
                    m_req_d = 1'b0;
                    m_we_d  = 1'b0;
                    d_ack_d = 1'b1;
                    // A write returns no data; keep the last read value.
                    if (!m_we_q) begin
                        d_rdata_d = m_rdata;
                    end
                end
            end

            // One dead cycle while the ack is visible. Requests are not
            // evaluated here, so a requester that has not yet dropped req
            // after its ack is not served a second time.
            ACK: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end

            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
                m_we_d  = 1'b0;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // State and registered outputs. An asynchronous reset abandons any
    // transaction in flight: m_req drops immediately and no ack is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            owner_q   <= OWN_NONE;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
            run_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            owner_q   <= owner_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
            run_q     <= run_d;
`endif
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign owner   = owner_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. It contains the following parts:
//   - A behavioural memory with a configurable or random wait-state count.
//   - Directed scenario tasks.
//   - A randomized run checked against a transaction-level reference model.
// The starve-guard expectations follow MEM_ARB_STARVE_GUARD_EN.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_D_RUN = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack;
    logic [1:0]    owner;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model controls: fixed wait count (>= 0) or random 0..2 (-1).
    int mem_wait = 0;
    bit spur_en  = 1'b0;
    logic [DW-1:0] mem_store [int unsigned];

    // Values the bench expects the rdata registers to hold.
    logic [DW-1:0] exp_i_rdata;
    logic [DW-1:0] exp_d_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_D_RUN(MAX_D_RUN)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .owner(owner)
    );

    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        int unsigned w;
        w = a[AW-1:2];
        if (mem_store.exists(w)) return mem_store[w];
        return 32'h1357_0000 ^ (w * 32'h9E37_79B9);
    endfunction

    // Memory responder. It drives m_ack/m_rdata on the falling edge, so the
    // DUT samples them at the next rising edge.
    initial begin : memory_model
        int wcnt;
        int tgt;
        wcnt    = 0;
        tgt     = 0;
        m_ack   = 1'b0;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            m_ack = 1'b0;
            if (m_req) begin
                if (wcnt == 0) tgt = (mem_wait >= 0) ? mem_wait : int'($urandom_range(0, 2));
                if (wcnt == tgt) begin
                    m_ack = 1'b1;
                    if (m_we) begin
                        mem_store[int'(m_addr[AW-1:2])] = m_wdata;
                        m_rdata = $urandom;
                    end else begin
                        m_rdata = mem_read(m_addr);
                    end
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt    = 0;
                m_rdata = $urandom;
                m_ack   = spur_en && ($urandom_range(0, 3) == 0);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) step();
        n_tests++;
        if ({i_ack, d_ack, m_req, m_we, owner} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ack/req/we/owner=%b want 000000", {i_ack, d_ack, m_req, m_we, owner});
        end
        n_tests++;
        if ({m_addr, m_wdata, i_rdata, d_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h wdata=%h ir=%h dr=%h want all 0", m_addr, m_wdata, i_rdata, d_rdata);
        end
        rst = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        step();
    endtask

    task automatic test_single_fetch();
        mem_wait = 0;
        mem_store[32'h104 >> 2] = 32'hC01F_0005;
        i_addr = 32'h104;
        i_req  = 1'b1;
        n_tests++;
        if ({m_req, owner} !== 3'b000) begin
            n_fail++;
            $display("FAIL fetch_c1: got req/owner=%b want 000", {m_req, owner});
        end
        step();
        n_tests++;
        if ({m_req, m_we, owner, i_ack} !== 5'b10010 || m_addr !== 32'h104) begin
            n_fail++;
            $display("FAIL fetch_c2: got req/we/owner/ack=%b addr=%h want 10010 addr=104", {m_req, m_we, owner, i_ack}, m_addr);
        end
        step();
        exp_i_rdata = 32'hC01F_0005;
        n_tests++;
        if ({i_ack, d_ack, m_req, owner} !== 5'b10001 || i_rdata !== exp_i_rdata) begin
            n_fail++;
            $display("FAIL fetch_c3: got ia/da/req/owner=%b rdata=%h want 10001 rdata=%h", {i_ack, d_ack, m_req, owner}, i_rdata, exp_i_rdata);
        end
        i_req = 1'b0;
        step();
        n_tests++;
        if ({i_ack, owner} !== 3'b000) begin
            n_fail++;
            $display("FAIL fetch_c4: got ack/owner=%b want 000", {i_ack, owner});
        end
    endtask

    task automatic test_data_write_wait();
        mem_wait = 2;
        d_we    = 1'b1;
        d_addr  = 32'h203;
        d_wdata = 32'hDEAD_BEEF;
        d_req   = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if ({m_req, m_we, owner, d_ack} !== 5'b11100 || m_addr !== 32'h200 || m_wdata !== 32'hDEAD_BEEF) begin
                n_fail++;
                $display("FAIL wr_wait_c%0d: got req/we/owner/ack=%b addr=%h wdata=%h want 11100 200 deadbeef", k + 2, {m_req, m_we, owner, d_ack}, m_addr, m_wdata);
            end
            step();
        end
        n_tests++;
        if ({d_ack, i_ack, m_req, m_we} !== 4'b1000 || d_rdata !== exp_d_rdata) begin
            n_fail++;
            $display("FAIL wr_ack_c5: got da/ia/req/we=%b d_rdata=%h want 1000 d_rdata=%h", {d_ack, i_ack, m_req, m_we}, d_rdata, exp_d_rdata);
        end
        n_tests++;
        if (mem_read(32'h200) !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL wr_mem: got mem[200]=%h want deadbeef", mem_read(32'h200));
        end
        d_req = 1'b0;
        d_we  = 1'b0;
        step();
    endtask

    task automatic test_simultaneous();
        mem_wait = 0;
        i_addr = 32'h300;
        d_addr = 32'h404;
        d_we   = 1'b0;
        i_req  = 1'b1;
        d_req  = 1'b1;
        step();
        n_tests++;
        if (owner !== 2'b10 || m_addr !== 32'h404) begin
            n_fail++;
            $display("FAIL simul_c2: got owner=%b addr=%h want 10 404", owner, m_addr);
        end
        step();
        exp_d_rdata = mem_read(32'h404);
        n_tests++;
        if ({d_ack, i_ack} !== 2'b10 || d_rdata !== exp_d_rdata) begin
            n_fail++;
            $display("FAIL simul_c3: got da/ia=%b d_rdata=%h want 10 %h", {d_ack, i_ack}, d_rdata, exp_d_rdata);
        end
        d_req = 1'b0;
        step();
        n_tests++;
        if ({m_req, owner, i_ack, d_ack} !== 5'b0) begin
            n_fail++;
            $display("FAIL simul_c4: got req/owner/ia/da=%b want 00000", {m_req, owner, i_ack, d_ack});
        end
        step();
        n_tests++;
        if ({m_req, owner} !== 3'b101 || m_addr !== 32'h300) begin
            n_fail++;
            $display("FAIL simul_c5: got req/owner=%b addr=%h want 101 300", {m_req, owner}, m_addr);
        end
        step();
        exp_i_rdata = mem_read(32'h300);
        n_tests++;
        if ({i_ack, d_ack} !== 2'b10 || i_rdata !== exp_i_rdata) begin
            n_fail++;
            $display("FAIL simul_c6: got ia/da=%b i_rdata=%h want 10 %h", {i_ack, d_ack}, i_rdata, exp_i_rdata);
        end
        i_req = 1'b0;
        step();
    endtask

    task automatic test_stale_hold();
        mem_wait = 0;
        d_we   = 1'b0;
        d_addr = 32'h500;
        d_req  = 1'b1;
        step();
        step();
        exp_d_rdata = mem_read(32'h500);
        n_tests++;
        if (d_ack !== 1'b1 || d_rdata !== exp_d_rdata) begin
            n_fail++;
            $display("FAIL stale_ack: got d_ack=%b d_rdata=%h want 1 %h", d_ack, d_rdata, exp_d_rdata);
        end
        // d_req stays high through the whole ack cycle, then drops.
        step();
        d_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if ({m_req, owner, d_ack} !== 4'b0) begin
                n_fail++;
                $display("FAIL stale_no_regrant_%0d: got req/owner/ack=%b want 0000", k, {m_req, owner, d_ack});
            end
            step();
        end
    endtask

    task automatic test_drop_early();
        mem_wait = 2;
        d_we   = 1'b0;
        d_addr = 32'h604;
        d_req  = 1'b1;
        step();
        d_req  = 1'b0;
        d_addr = 32'hFFF0;
        step();
        step();
        step();
        exp_d_rdata = mem_read(32'h604);
        n_tests++;
        if (d_ack !== 1'b1 || d_rdata !== exp_d_rdata) begin
            n_fail++;
            $display("FAIL drop_early: got d_ack=%b d_rdata=%h want 1 %h", d_ack, d_rdata, exp_d_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid_op();
        mem_wait = 5;
        d_we   = 1'b0;
        d_addr = 32'h700;
        d_req  = 1'b1;
        step();
        n_tests++;
        if (m_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got m_req=%b want 1", m_req);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({m_req, owner, i_ack, d_ack} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_mid_drop: got req/owner/ia/da=%b want 00000", {m_req, owner, i_ack, d_ack});
        end
        d_req = 1'b0;
        step();
        step();
        rst = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        mem_wait = 0;
        i_addr = 32'h10C;
        i_req  = 1'b1;
        step();
        n_tests++;
        if ({m_req, owner} !== 3'b101 || m_addr !== 32'h10C) begin
            n_fail++;
            $display("FAIL rst_mid_regrant: got req/owner=%b addr=%h want 101 10c", {m_req, owner}, m_addr);
        end
        step();
        exp_i_rdata = mem_read(32'h10C);
        n_tests++;
        if (i_ack !== 1'b1 || i_rdata !== exp_i_rdata || d_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_ack: got ia=%b da=%b i_rdata=%h want 1 0 %h", i_ack, d_ack, i_rdata, exp_i_rdata);
        end
        i_req = 1'b0;
        step();
    endtask

    task automatic test_starve();
        logic [1:0] grants [$];
        bit         p_mreq;
        mem_wait = 0;
        i_addr = 32'h800;
        d_addr = 32'h900;
        d_we   = 1'b0;
        i_req  = 1'b1;
        d_req  = 1'b1;
        p_mreq = 1'b0;
        for (int c = 0; c < 100 && grants.size() < 10; c++) begin
            step();
            if (m_req && !p_mreq) grants.push_back(owner);
            p_mreq = m_req;
        end
        n_tests++;
        if (grants.size() != 10) begin
            n_fail++;
            $display("FAIL starve_count: got %0d grants want 10", grants.size());
        end
        for (int g = 0; g < grants.size(); g++) begin
            logic [1:0] want;
`ifdef MEM_ARB_STARVE_GUARD_EN
            want = ((g % (MAX_D_RUN + 1)) == MAX_D_RUN) ? 2'b01 : 2'b10;
`else
            want = 2'b10;
`endif
            n_tests++;
            if (grants[g] !== want) begin
                n_fail++;
                $display("FAIL starve_grant_%0d: got owner=%b want %b", g, grants[g], want);
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (4) step();
    endtask

    // Randomized traffic. The model tracks pending requests at transaction
    // level and predicts the grant, the bus contents, the ack, and the data.
    task automatic test_random();
        bit            p_idle, p_i, p_d, p_mack, p_mreq;
        bit            ipend, dpend, dwe, win_d;
        int            cur, run, n_i, n_d;
        logic [AW-1:0] ia, da, exp_addr;
        logic [DW-1:0] dwd;
        logic          exp_we;

        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        i_req = 1'b0;
        d_req = 1'b0;
        mem_wait = -1;
        spur_en  = 1'b1;
        p_idle = 1'b1; p_i = 1'b0; p_d = 1'b0; p_mack = 1'b0; p_mreq = 1'b0;
        ipend = 1'b0; dpend = 1'b0; dwe = 1'b0;
        cur = 0; run = 0; n_i = 0; n_d = 0;
        ia = '0; da = '0; dwd = '0; exp_addr = '0; exp_we = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (p_idle) begin
                if (p_i || p_d) begin
                    win_d = p_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
                    if (p_d && p_i && run == MAX_D_RUN) win_d = 1'b0;
                    if (!p_i) run = 0;
                    else if (win_d) run++;
                    else run = 0;
`endif
                    cur      = win_d ? 2 : 1;
                    exp_addr = win_d ? {da[AW-1:2], 2'b00} : {ia[AW-1:2], 2'b00};
                    exp_we   = win_d ? dwe : 1'b0;
                    n_tests++;
                    if (m_req !== 1'b1 || owner !== 2'(cur) || m_addr !== exp_addr || m_we !== exp_we
                        || (exp_we && m_wdata !== dwd)) begin
                        n_fail++;
                        $display("FAIL rnd_grant cyc=%0d: got req=%b owner=%b addr=%h we=%b wdata=%h want 1 %b %h %b %h",
                                 cyc, m_req, owner, m_addr, m_we, m_wdata, 2'(cur), exp_addr, exp_we, dwd);
                    end
                end else begin
`ifdef MEM_ARB_STARVE_GUARD_EN
                    run = 0;
`endif
                    n_tests++;
                    if ({m_req, owner} !== 3'b000) begin
                        n_fail++;
                        $display("FAIL rnd_idle cyc=%0d: got req/owner=%b want 000", cyc, {m_req, owner});
                    end
                end
            end else if (p_mreq) begin
                if (p_mack) begin
                    if (cur == 1) exp_i_rdata = mem_read(ia);
                    else if (!dwe) exp_d_rdata = mem_read(da);
                    n_tests++;
                    if ({m_req, m_we} !== 2'b00 || owner !== 2'(cur) || {i_ack, d_ack} !== ((cur == 1) ? 2'b10 : 2'b01)
                        || i_rdata !== exp_i_rdata || d_rdata !== exp_d_rdata) begin
                        n_fail++;
                        $display("FAIL rnd_ack cyc=%0d: got req/we=%b owner=%b ia/da=%b ir=%h dr=%h want 00 %b %0d ir=%h dr=%h",
                                 cyc, {m_req, m_we}, owner, {i_ack, d_ack}, i_rdata, d_rdata, 2'(cur), cur, exp_i_rdata, exp_d_rdata);
                    end
                end else begin
                    n_tests++;
                    if (m_req !== 1'b1 || owner !== 2'(cur) || m_addr !== exp_addr || m_we !== exp_we || {i_ack, d_ack} !== 2'b00) begin
                        n_fail++;
                        $display("FAIL rnd_wait cyc=%0d: got req=%b owner=%b addr=%h we=%b acks=%b want 1 %b %h %b 00",
                                 cyc, m_req, owner, m_addr, m_we, {i_ack, d_ack}, 2'(cur), exp_addr, exp_we);
                    end
                end
            end else begin
                n_tests++;
                if ({m_req, owner, i_ack, d_ack} !== 5'b0) begin
                    n_fail++;
                    $display("FAIL rnd_post_ack cyc=%0d: got req/owner/ia/da=%b want 00000", cyc, {m_req, owner, i_ack, d_ack});
                end
            end

            p_idle = !m_req && !i_ack && !d_ack;
            p_mreq = m_req;
            p_mack = m_ack;

            if (i_ack) begin
                ipend = 1'b0;
                i_req = 1'b0;
                n_i++;
            end else if (!ipend && $urandom_range(0, 3) == 0) begin
                ia     = $urandom;
                i_addr = ia;
                ipend  = 1'b1;
                i_req  = 1'b1;
            end
            if (d_ack) begin
                dpend = 1'b0;
                d_req = 1'b0;
                n_d++;
            end else if (!dpend && $urandom_range(0, 3) == 0) begin
                da      = 32'($urandom_range(0, 1023));
                dwe     = 1'($urandom_range(0, 1));
                dwd     = $urandom;
                d_addr  = da;
                d_we    = dwe;
                d_wdata = dwd;
                dpend   = 1'b1;
                d_req   = 1'b1;
            end
            p_i = i_req;
            p_d = d_req;
        end
        n_tests++;
        if (n_i < 10 || n_d < 10) begin
            n_fail++;
            $display("FAIL rnd_progress: got %0d fetch and %0d data acks want at least 10 each", n_i, n_d);
        end
        $display("[TB] random run: %0d fetch and %0d data transactions", n_i, n_d);
        spur_en = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (6) step();
    endtask

    initial begin
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        test_reset();
        test_single_fetch();
        test_data_write_wait();
        test_simultaneous();
        test_stale_hold();
        test_drop_early();
        test_reset_mid_op();
        test_starve();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified single-port memory bus between the pipeline's instruction-fetch port and data-access port.
- Lets the core run against a single external RAM instead of split I/D memories.
- Runs a request/acknowledge transaction FSM and returns read data and completion strobes to each requester.
- Requesters use the ack strobes to drive their stall logic.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- MAX_D_RUN, 4, consecutive data grants allowed while an instruction request waits (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- i_req  in  1  fetch request (read only); held high until i_ack.
- i_addr  in  AW  fetch byte address; stable while i_req is high.
- i_rdata  out  DW  fetch read data; valid in the i_ack cycle.
- i_ack  out  1  one-cycle fetch completion strobe.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  in  AW  data byte address.
- d_wdata  in  DW  write data.
- d_rdata  out  DW  data read data; valid in the d_ack cycle.
- d_ack  out  1  one-cycle data completion strobe.
- m_req  out  1  memory request; held until m_ack.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory word address; bits [1:0] forced to 0.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data; valid when m_ack=1.
- m_ack  in  1  memory completion; one cycle, at least 0 cycles after m_req rises.
- owner  out  2  current owner: 00 none, 01 instruction, 10 data.

Behaviour:
- Reset values: state IDLE, counter 0. All outputs 0: i_ack, d_ack, m_req, m_we, m_addr, m_wdata, owner, i_rdata, d_rdata.
- Reset is asynchronous. Asserting it mid-transaction drops m_req in the same cycle and abandons the transaction. No ack is issued for it.
- All outputs are registered.
- State IDLE: m_req=0, owner=00. Grant is evaluated each cycle.
  - d_req=1: latch d_addr, d_we, d_wdata; go to D_WAIT.
  - else i_req=1: latch i_addr; m_we=0; go to I_WAIT.
  - Both requests high: data wins. Data belongs to the older instruction.
- States I_WAIT / D_WAIT:
  - m_req=1. m_addr, m_we, m_wdata are driven from the latched values and stay stable until m_ack.
  - owner = 01 or 10.
  - On m_ack=1: capture m_rdata into the owner's rdata register (writes capture nothing; rdata holds its old value). Go to ACK.
  - New requests are ignored while in these states.
- State ACK:
  - m_req=0 and m_we=0.
  - The owner's ack=1 for exactly this cycle. The other ack stays 0.
  - Next state is unconditionally IDLE.
  - Requests are not evaluated here, so a requester still holding req after its own ack is not re-granted on stale data.
- Latency: with m_ack returned in the first WAIT cycle, req-high to ack takes 3 cycles (IDLE grant, WAIT, ACK).
  - Back-to-back transactions take 3 cycles each.
  - Each extra memory wait cycle adds 1.
- rdata registers hold their value until the next read by the same requester.
- m_ack while in IDLE or ACK is ignored.
- Address arithmetic: m_addr = {latched_addr[AW-1:2], 2'b00}. No wrap checking; the address passes through unchanged otherwise.
- A requester dropping req before its ack is a protocol violation. The arbiter still completes the latched transaction and issues the ack.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A run counter increments on each data grant made while i_req=1.
  - The counter clears on any instruction grant, or in any IDLE cycle with i_req=0.
  - When the counter equals MAX_D_RUN, the next IDLE with i_req=1 grants instruction even if d_req=1.
- Not defined:
  - Pure fixed priority; data always wins.
  - No counter logic is synthesised.

Test Plan:
- Single fetch: i_req=1, i_addr=0x104, memory returns m_ack in the first WAIT cycle with m_rdata=0xC01F0005 -> m_addr=0x104, m_we=0; i_ack high in cycle 3 with i_rdata=0xC01F0005; owner sequence 00,01,01→00.
- Data write with 2 wait states: d_req=1, d_we=1, d_addr=0x203, d_wdata=0xDEADBEEF -> m_addr=0x200, m_we=1, m_wdata=0xDEADBEEF held 3 cycles; d_ack at cycle 5; d_rdata unchanged.
- Simultaneous: i_req and d_req rise together -> data served first (d_ack at cycle 3); instruction granted at cycle 4 IDLE; i_ack at cycle 6.
- Stale hold: after d_ack, d_req held for 1 more cycle and then dropped -> no second memory transaction; m_req stays 0.
- Reset mid-op: rst asserted during D_WAIT -> m_req, owner, and acks 0 in the same cycle; after release, i_req=1 is granted normally.
- Starve guard (macro on, MAX_D_RUN=4): d_req and i_req held continuously -> grants D,D,D,D,I,D...; macro off -> D only while d_req is held.
